mem_copy_engine: RTL and testbench
==================================

Name: mem_copy_engine

Overview:
- Initiator-side block-copy engine that drives the read and write ports of the 8-bit data memory.
- Accepts one command (source, destination, length) and copies length words from source to destination, one read and one write per word.
- Raises a done pulse when the copy finishes.
- Sits between the control FSM / testbench command source and the data memory.

Parameters:
- DATA_WIDTH, 8, word width; must match the memory.
- MEMORY_SIZE, 64, number of memory words; address width AW = $clog2(MEMORY_SIZE).
- LW, $clog2(MEMORY_SIZE)+1, length field width; allows a full-memory copy.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- src_addr  in  AW  first source word address.
- dst_addr  in  AW  first destination word address.
- length  in  LW  number of words to copy, 0..MEMORY_SIZE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the copy completes.
- mem_read  out  1  memory read enable.
- mem_read_addr  out  AW  memory read address.
- mem_read_data  in  DATA_WIDTH  data registered by the memory on the edge that ends the mem_read cycle.
- mem_write  out  1  memory write enable.
- mem_write_addr  out  AW  memory write address.
- mem_write_data  out  DATA_WIDTH  memory write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy, done, mem_read and mem_write are 0.
  - All address registers, data registers and the remaining-word counter are 0.
  - Reset mid-copy aborts immediately; no further memory accesses are issued; no done pulse.
- States: IDLE, READ, WRITE, FINISH.
- IDLE:
  - start=1 latches src, dst and length into rd_ptr, wr_ptr and remaining.
  - Next state is READ if length>0, else FINISH.
- READ: mem_read=1, mem_read_addr=rd_ptr; next state WRITE.
- WRITE:
  - mem_write=1, mem_write_addr=wr_ptr, mem_write_data=mem_read_data (combinational pass-through; valid because the memory latched it at the end of READ).
  - Increment rd_ptr and wr_ptr; decrement remaining.
  - Next state is READ if the decremented remaining>0, else FINISH.
- FINISH: done=1 for exactly one cycle; next state IDLE.
- busy=1 in READ, WRITE and FINISH; 0 in IDLE.
- Throughput: 2 cycles per word. Start-accept edge to done pulse = 2*length+1 cycles; length=0 gives done on the cycle right after the accept.
- mem_read and mem_write are never asserted in the same cycle.
- Pointers wrap modulo MEMORY_SIZE (natural AW-bit overflow), e.g. src=62, length=4 reads addresses 62, 63, 0, 1.
- Length >MEMORY_SIZE is clamped to MEMORY_SIZE at accept.
- start while busy is ignored; no queueing.
- start held high in FINISH is ignored; it is accepted in the following IDLE cycle.
- Command inputs are don't-care except in the cycle start is accepted.

Optional Feature:
- Macro: MEM_COPY_OVERLAP_SAFE_EN.
- Defined:
  - At accept, if dst is ahead of src modulo MEMORY_SIZE and (dst-src) mod MEMORY_SIZE < length, the copy runs descending.
  - Descending start points: rd_ptr=src+length-1, wr_ptr=dst+length-1, both decremented per word.
  - Result: destination equals the original source contents.
- Undefined: always ascending; overlapping forward copies replicate data. This is documented behaviour, not an error.

Decomposition:
- Package mem_copy_pkg:
  - State enum (IDLE, READ, WRITE, FINISH).
  - Default DATA_WIDTH and MEMORY_SIZE constants.
- One sub-module, mem_copy_ptr: an AW-bit up/down pointer with load, step and direction inputs, instantiated twice (read and write pointers).

Test Plan:
- Preload mem[0..3]=11,22,33,44; start src=0, dst=10, length=4 -> mem[10..13]=11,22,33,44; done exactly 9 cycles after accept; busy high for 8 cycles before done.
- length=0, src=5, dst=6 -> no mem_read/mem_write pulses; done on the cycle after accept; memory unchanged.
- Wrap: mem[62]=A1, mem[63]=A2, mem[0]=A3; start src=62, dst=20, length=3 -> mem[20..22]=A1,A2,A3.
- start re-pulsed every cycle during a length=4 copy -> only one copy, one done pulse; the next start after done is accepted.
- reset asserted after the 2nd write of a length=6 copy -> outputs go 0 asynchronously; exactly 2 destination words written.
- Overlap: mem[0..3]=1,2,3,4, src=0, dst=2, length=4. With MEM_COPY_OVERLAP_SAFE_EN -> mem[2..5]=1,2,3,4. Without -> mem[2..5]=1,2,1,2.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared types and default sizing for the block-copy engine.
package mem_copy_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_MEMORY_SIZE = 64;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    FINISH
  } state_t;

endpackage

// File: rtl/mem_copy_ptr.sv
// AW-bit address pointer with load, single-step and up/down direction; wraps naturally.
module mem_copy_ptr
  import mem_copy_pkg::*;
#(
  parameter int unsigned AW = $clog2(DEF_MEMORY_SIZE)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [AW-1:0] i_load_val,
  input  logic          i_step,
  input  logic          i_down,
  output logic [AW-1:0] o_ptr
);

  logic [AW-1:0] r_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_load) begin
      r_ptr <= i_load_val;
    end else if (i_step) begin
      r_ptr <= i_down ? r_ptr - 1'b1 : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/mem_copy_engine.sv
// Block-copy engine: one read then one write per word, done pulse at the end.
// Define MEM_COPY_OVERLAP_SAFE_EN to copy overlapping forward regions in descending order.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int unsigned MEMORY_SIZE = DEF_MEMORY_SIZE,
  parameter  int unsigned LW          = $clog2(MEMORY_SIZE) + 1,
  localparam int unsigned AW          = $clog2(MEMORY_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [AW-1:0]         src_addr,
  input  logic [AW-1:0]         dst_addr,
  input  logic [LW-1:0]         length,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_read,
  output logic [AW-1:0]         mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write,
  output logic [AW-1:0]         mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data
);

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_mem_read;
  logic          r_mem_write;
  logic [LW-1:0] r_remaining;

  logic [LW-1:0] w_len_clamped;
  logic [LW-1:0] w_rem_next;
  logic          w_accept;
  logic          w_step;
  logic          w_down;
  logic [AW-1:0] w_rd_load;
  logic [AW-1:0] w_wr_load;
  logic [AW-1:0] w_rd_ptr;
  logic [AW-1:0] w_wr_ptr;

  assign w_len_clamped = (length > LW'(MEMORY_SIZE)) ? LW'(MEMORY_SIZE) : length;
  assign w_rem_next    = r_remaining - LW'(1);
  assign w_accept      = (r_state == IDLE) && start;
  assign w_step        = (r_state == WRITE);

`ifdef MEM_COPY_OVERLAP_SAFE_EN
  logic          r_desc;
  logic [AW-1:0] w_gap;
  logic [AW-1:0] w_len_m1;
  logic          w_desc_now;

  // Destination overlapping the tail of the source: walk both regions from the top down.
  assign w_gap      = dst_addr - src_addr;
  assign w_len_m1   = AW'(w_len_clamped - LW'(1));
  assign w_desc_now = (w_gap != '0) && (LW'(w_gap) < w_len_clamped);
  assign w_rd_load  = w_desc_now ? src_addr + w_len_m1 : src_addr;
  assign w_wr_load  = w_desc_now ? dst_addr + w_len_m1 : dst_addr;
  assign w_down     = r_desc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_desc <= 1'b0;
    end else if (w_accept) begin
      r_desc <= w_desc_now;
    end
  end
`else
  assign w_rd_load = src_addr;
  assign w_wr_load = dst_addr;
  assign w_down    = 1'b0;
`endif

  mem_copy_ptr #(.AW(AW)) u_rd_ptr (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_load     (w_accept),
    .i_load_val (w_rd_load),
    .i_step     (w_step),
    .i_down     (w_down),
    .o_ptr      (w_rd_ptr)
  );

  mem_copy_ptr #(.AW(AW)) u_wr_ptr (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_load     (w_accept),
    .i_load_val (w_wr_load),
    .i_step     (w_step),
    .i_down     (w_down),
    .o_ptr      (w_wr_ptr)
  );

  // Strobes are registered alongside the next state so they track it exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_remaining <= w_len_clamped;
            r_busy      <= 1'b1;
            if (w_len_clamped != '0) begin
              r_state    <= READ;
              r_mem_read <= 1'b1;
            end else begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end
          end
        end
        READ: begin
          r_state     <= WRITE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b1;
        end
        WRITE: begin
          r_mem_write <= 1'b0;
          r_remaining <= w_rem_next;
          if (w_rem_next != '0) begin
            r_state    <= READ;
            r_mem_read <= 1'b1;
          end else begin
            r_state <= FINISH;
            r_done  <= 1'b1;
          end
        end
        FINISH: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign mem_read       = r_mem_read;
  assign mem_read_addr  = w_rd_ptr;
  assign mem_write      = r_mem_write;
  assign mem_write_addr = w_wr_ptr;
  assign mem_write_data = r_mem_write ? mem_read_data : '0;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a behavioural 64x8 memory.
module tb_mem_copy_engine;

  localparam int MS = 64;
  localparam int AW = 6;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy;
  logic          done;
  logic          mem_read;
  logic [AW-1:0] mem_read_addr;
  logic [7:0]    mem_read_data = '0;
  logic          mem_write;
  logic [AW-1:0] mem_write_addr;
  logic [7:0]    mem_write_data;

  logic [7:0] mem [MS];

  int n_checks = 0;
  int n_fail   = 0;

  mem_copy_engine #(.DATA_WIDTH(8), .MEMORY_SIZE(MS)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .mem_read       (mem_read),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data),
    .mem_write      (mem_write),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_read)  mem_read_data <= mem[mem_read_addr];
    if (mem_write) mem[mem_write_addr] <= mem_write_data;
  end

  task automatic clear_mem(input logic [7:0] v);
    for (int i = 0; i < MS; i++) mem[i] <= v;
    #1;
  endtask

  // Issues one command and samples each cycle after the accept edge until done.
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l,
                          output int cyc, output int busy_n, output int rd_n,
                          output int wr_n, output int both_n);
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; busy_n = 0; rd_n = 0; wr_n = 0; both_n = 0;
    forever begin
      cyc++;
      if (busy && !done) busy_n++;
      if (mem_read) rd_n++;
      if (mem_write) wr_n++;
      if (mem_read && mem_write) both_n++;
      if (done) break;
      if (cyc >= 400) begin cyc = -1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({busy, done, mem_read, mem_write} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {busy, done, mem_read, mem_write});
    end
    n_checks++;
    if ({mem_read_addr, mem_write_addr, mem_write_data} !== '0) begin
      n_fail++; $display("FAIL reset_addr_data: got %h/%h/%h expected 0/0/0", mem_read_addr, mem_write_addr, mem_write_data);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int cyc, bn, rn, wn, bothn;
    logic [7:0] exp [4] = '{8'd11, 8'd22, 8'd33, 8'd44};
    clear_mem(8'h00);
    for (int i = 0; i < 4; i++) mem[i] <= exp[i];
    #1;
    run_copy(6'd0, 6'd10, 7'd4, cyc, bn, rn, wn, bothn);
    n_checks++;
    if (cyc !== 9) begin n_fail++; $display("FAIL basic_latency: got %0d expected 9", cyc); end
    n_checks++;
    if (bn !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 8", bn); end
    n_checks++;
    if (rn !== 4 || wn !== 4) begin n_fail++; $display("FAIL basic_access_count: got rd=%0d wr=%0d expected 4/4", rn, wn); end
    n_checks++;
    if (bothn !== 0) begin n_fail++; $display("FAIL basic_rd_wr_exclusive: got %0d expected 0", bothn); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[10+i] !== exp[i]) begin n_fail++; $display("FAIL basic_data[%0d]: got %0d expected %0d", 10+i, mem[10+i], exp[i]); end
    end
    n_checks++;
    if (mem[9] !== 8'h00 || mem[14] !== 8'h00) begin
      n_fail++; $display("FAIL basic_neighbours: got %h/%h expected 00/00", mem[9], mem[14]);
    end
  endtask

  task automatic test_zero_length();
    int cyc, bn, rn, wn, bothn, diffs;
    clear_mem(8'h5A);
    mem[5] <= 8'h77;
    #1;
    run_copy(6'd5, 6'd6, 7'd0, cyc, bn, rn, wn, bothn);
    n_checks++;
    if (cyc !== 1) begin n_fail++; $display("FAIL zero_latency: got %0d expected 1", cyc); end
    n_checks++;
    if (rn !== 0 || wn !== 0) begin n_fail++; $display("FAIL zero_accesses: got rd=%0d wr=%0d expected 0/0", rn, wn); end
    diffs = 0;
    for (int i = 0; i < MS; i++) if (mem[i] !== ((i == 5) ? 8'h77 : 8'h5A)) diffs++;
    n_checks++;
    if (diffs !== 0) begin n_fail++; $display("FAIL zero_mem_unchanged: got %0d changed words expected 0", diffs); end
  endtask

  task automatic test_wrap();
    int cyc, bn, rn, wn, bothn;
    logic [7:0] exp [3] = '{8'hA1, 8'hA2, 8'hA3};
    clear_mem(8'h00);
    mem[62] <= 8'hA1; mem[63] <= 8'hA2; mem[0] <= 8'hA3;
    #1;
    run_copy(6'd62, 6'd20, 7'd3, cyc, bn, rn, wn, bothn);
    n_checks++;
    if (cyc !== 7) begin n_fail++; $display("FAIL wrap_latency: got %0d expected 7", cyc); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (mem[20+i] !== exp[i]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", 20+i, mem[20+i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int done_n, done_at;
    bit seen;
    clear_mem(8'h00);
    for (int i = 0; i < 4; i++) mem[i] <= 8'h10 + 8'(i);
    #1;
    src_addr = 6'd0; dst_addr = 6'd30; length = 7'd4; start = 1'b1;
    @(posedge clk); #1;
    done_n = 0; done_at = 0;
    for (int k = 1; k <= 9; k++) begin
      if (done) begin done_n++; done_at = k; end
      if (k < 9) begin @(posedge clk); #1; end
    end
    n_checks++;
    if (done_n !== 1 || done_at !== 9) begin
      n_fail++; $display("FAIL b2b_single_done: got count=%0d at=%0d expected 1 at 9", done_n, done_at);
    end
    src_addr = 6'd0; dst_addr = 6'd40; length = 7'd1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_finish_ignores_start: got busy=%b done=%b expected 0/0", busy, done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || mem_read !== 1'b1 || mem_read_addr !== 6'd0) begin
      n_fail++; $display("FAIL b2b_next_accept: got busy=%b rd=%b addr=%0d expected 1/1/0", busy, mem_read, mem_read_addr);
    end
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL b2b_second_done: got none expected pulse"); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[30+i] !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", 30+i, mem[30+i], 8'h10 + 8'(i)); end
    end
    n_checks++;
    if (mem[40] !== 8'h10 || mem[34] !== 8'h00) begin
      n_fail++; $display("FAIL b2b_second_copy: got %h/%h expected 10/00", mem[40], mem[34]);
    end
  endtask

  task automatic test_reset_abort();
    clear_mem(8'hEE);
    for (int i = 0; i < 6; i++) mem[i] <= 8'h61 + 8'(i);
    #1;
    src_addr = 6'd0; dst_addr = 6'd50; length = 7'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, mem_read, mem_write} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_async_outputs: got %b expected 0000", {busy, done, mem_read, mem_write});
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (mem[50+i] !== ((i < 2) ? 8'h61 + 8'(i) : 8'hEE)) begin
        n_fail++; $display("FAIL abort_dst[%0d]: got %h expected %h", 50+i, mem[50+i], (i < 2) ? 8'h61 + 8'(i) : 8'hEE);
      end
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got busy=%b done=%b expected 0/0", busy, done); end
  endtask

  task automatic test_overlap();
    int cyc, bn, rn, wn, bothn;
`ifdef MEM_COPY_OVERLAP_SAFE_EN
    logic [7:0] exp [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
`else
    logic [7:0] exp [4] = '{8'd1, 8'd2, 8'd1, 8'd2};
`endif
    clear_mem(8'h00);
    for (int i = 0; i < 4; i++) mem[i] <= 8'(i + 1);
    #1;
    run_copy(6'd0, 6'd2, 7'd4, cyc, bn, rn, wn, bothn);
    n_checks++;
    if (cyc !== 9) begin n_fail++; $display("FAIL overlap_latency: got %0d expected 9", cyc); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[2+i] !== exp[i]) begin n_fail++; $display("FAIL overlap_data[%0d]: got %0d expected %0d", 2+i, mem[2+i], exp[i]); end
    end
  endtask

  task automatic test_clamp();
    int cyc, bn, rn, wn, bothn;
    run_copy(6'd0, 6'd0, 7'd100, cyc, bn, rn, wn, bothn);
    n_checks++;
    if (cyc !== 129) begin n_fail++; $display("FAIL clamp_latency: got %0d expected 129", cyc); end
    n_checks++;
    if (rn !== 64 || wn !== 64) begin n_fail++; $display("FAIL clamp_accesses: got rd=%0d wr=%0d expected 64/64", rn, wn); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_wrap();
    test_back_to_back();
    test_reset_abort();
    test_overlap();
    test_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
